// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the TPU run sequencer.
package tpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP    = 3'd1,
      S_LOAD   = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } tpu_run_state_t;

   localparam int TPU_MATRIX_SIZE  = 8;
   localparam int TPU_NUM_PE_ROWS  = 8;
   localparam int TPU_DRAIN_CYCLES = TPU_MATRIX_SIZE + TPU_NUM_PE_ROWS;

   // Tile counter must hold 0..depth inclusive.
   function automatic int tile_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/tpu_run_ctrl_if.sv
// Host command port of the run sequencer: valid/ready handshake plus command fields.
interface tpu_run_ctrl_if #(
   parameter int ADDRESSSIZE = 10,
   parameter int FIFO_DEPTH  = 4
);
   localparam int TW = tpu_pkg::tile_cnt_w(FIFO_DEPTH);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [ADDRESSSIZE-1:0] cmd_base;
   logic [ADDRESSSIZE:0]   cmd_len;
   logic [TW-1:0]          cmd_tiles;

   modport master (
      output cmd_valid, cmd_base, cmd_len, cmd_tiles,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_base, cmd_len, cmd_tiles,
      output cmd_ready
   );

endinterface

// File: rtl/tpu_addr_gen.sv
// Activation row counter: emits base+k modulo 2^ADDRESSSIZE and flags the last row of a tile.
module tpu_addr_gen import tpu_pkg::*; #(
   parameter int ADDRESSSIZE = 10
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   clr,
   input  logic                   step,
   input  logic [ADDRESSSIZE-1:0] base,
   input  logic [ADDRESSSIZE:0]   len,
   output logic [ADDRESSSIZE-1:0] address,
   output logic                   last
);

   localparam int LW = ADDRESSSIZE + 1;

   // One bit wider than the address so k can reach len == 2^ADDRESSSIZE.
   logic [LW-1:0] k;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         k <= '0;
      end else if (clr) begin
         k <= '0;
      end else if (step) begin
         k <= k + LW'(1);
      end
   end

   assign address = base + k[ADDRESSSIZE-1:0];
   assign last    = (k == len - LW'(1));

endmodule

// File: rtl/tpu_run_ctrl.sv
// Command-driven run sequencer for the systolic-array TPU: pop weights, load PEs,
// stream activation addresses, drain, repeat per tile.
//
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   POP    | popping one weight tile, stalls while the FIFO is empty
//   LOAD   | we_rl pulse latches the popped tile into the PEs
//   STREAM | one live activation address per cycle, k = 0..len-1
//   DRAIN  | pipeline drain, all strobes low
//   DONE   | done (and err) pulse, back to IDLE
module tpu_run_ctrl import tpu_pkg::*; #(
   parameter int ADDRESSSIZE  = 10,
   parameter int NUM_PE_ROWS  = TPU_NUM_PE_ROWS,
   parameter int MATRIX_SIZE  = TPU_MATRIX_SIZE,
   parameter int FIFO_DEPTH   = 4,
   parameter int DRAIN_CYCLES = MATRIX_SIZE + NUM_PE_ROWS
) (
   input  logic                   clk,
   input  logic                   rstn,
   tpu_run_ctrl_if.slave          cmd,
   input  logic                   abort,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   start,
   output logic                   we_rl,
   output logic                   valid_address,
   output logic [ADDRESSSIZE-1:0] sram_address,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   aborted
);

   localparam int TW = tile_cnt_w(FIFO_DEPTH);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [TW-1:0] DEPTH_T    = TW'(FIFO_DEPTH);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   tpu_run_state_t         state;
   logic [ADDRESSSIZE-1:0] base_q;
   logic [ADDRESSSIZE:0]   len_q;
   logic [TW-1:0]          tiles_q;
   logic [TW-1:0]          t_cnt;
   logic [TW-1:0]          t_inc;
   logic [DW-1:0]          drain_cnt;
   logic                   cmd_ready_q;
   logic                   busy_q;
   logic                   we_rl_q;
   logic                   valid_q;
   logic                   done_q;
   logic                   err_q;
   logic                   aborted_q;

   logic                   addr_clr;
   logic                   addr_step;
   logic                   addr_last;
   logic [ADDRESSSIZE-1:0] addr;

   assign t_inc     = t_cnt + TW'(1);
   assign addr_clr  = ((state == S_IDLE) && cmd.cmd_valid) ||
                      ((state == S_DRAIN) && (drain_cnt == '0));
   assign addr_step = (state == S_STREAM);

   tpu_addr_gen #(
      .ADDRESSSIZE (ADDRESSSIZE)
   ) u_addr_gen (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (addr_clr),
      .step    (addr_step),
      .base    (base_q),
      .len     (len_q),
      .address (addr),
      .last    (addr_last)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= S_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         tiles_q     <= '0;
         t_cnt       <= '0;
         drain_cnt   <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         we_rl_q     <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         we_rl_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
         // Abort wins over everything, including a pop issued this same cycle.
         if (abort && (state != S_IDLE)) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            aborted_q   <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cmd.cmd_valid) begin
                     base_q      <= cmd.cmd_base;
                     len_q       <= cmd.cmd_len;
                     tiles_q     <= cmd.cmd_tiles;
                     t_cnt       <= '0;
                     cmd_ready_q <= 1'b0;
                     busy_q      <= 1'b1;
                     if ((cmd.cmd_tiles == '0) || (cmd.cmd_tiles > DEPTH_T)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        err_q  <= (cmd.cmd_tiles > DEPTH_T);
                     end else begin
                        state <= S_POP;
                     end
                  end
               end
               S_POP: begin
                  if (!fifo_empty) begin
                     state   <= S_LOAD;
                     we_rl_q <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (len_q != '0) begin
                     state   <= S_STREAM;
                     valid_q <= 1'b1;
                  end else begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                  end
               end
               S_STREAM: begin
                  if (addr_last) begin
                     state     <= S_DRAIN;
                     valid_q   <= 1'b0;
                     drain_cnt <= DRAIN_LOAD;
                  end
               end
               S_DRAIN: begin
                  if (drain_cnt == '0) begin
                     t_cnt <= t_inc;
                     if (t_inc < tiles_q) begin
                        state <= S_POP;
                     end else begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                     end
                  end else begin
                     drain_cnt <= drain_cnt - DW'(1);
                  end
               end
               S_DONE: begin
                  state       <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
               default: begin
                  state       <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  valid_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   // Pop and start follow fifo_empty in the same cycle so a stalled POP never pops.
   assign fifo_read_enable = (state == S_POP) && !fifo_empty;
   assign start            = (state == S_POP) && (t_cnt == '0) && !fifo_empty;

   assign cmd.cmd_ready = cmd_ready_q;
   assign busy          = busy_q;
   assign we_rl         = we_rl_q;
   assign valid_address = valid_q;
   assign sram_address  = valid_q ? addr : '0;
   assign done          = done_q;
   assign err           = err_q;
   assign aborted       = aborted_q;

endmodule

// File: tb/tb_tpu_run_ctrl.sv
// Directed bench for tpu_run_ctrl: address scoreboard, per-cycle strobe checks and
// per-command timing/count checks.
module tb_tpu_run_ctrl;

   localparam int AW    = 10;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic abort = 1'b0;
   logic fifo_empty = 1'b0;
   logic fifo_read_enable, start, we_rl, valid_address, busy, done, err, aborted;
   logic [AW-1:0] sram_address;

   int nchecks = 0;
   int nerrors = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   int n_start, n_we, n_valid, n_done, n_err, n_abort;
   int done_cyc, start_cyc, we_cyc, err_cyc;
   int pop_cycs[$];
   logic [AW-1:0] exp_q[$];

   tpu_run_ctrl_if #(.ADDRESSSIZE(AW), .FIFO_DEPTH(DEPTH)) cmd_bus();

   tpu_run_ctrl #(
      .ADDRESSSIZE (AW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .cmd              (cmd_bus),
      .abort            (abort),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .start            (start),
      .we_rl            (we_rl),
      .valid_address    (valid_address),
      .sram_address     (sram_address),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .aborted          (aborted)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         cyc++;
         if (fifo_read_enable) pop_cycs.push_back(cyc);
         if (start) begin n_start++; if (start_cyc < 0) start_cyc = cyc; end
         if (we_rl) begin n_we++; if (we_cyc < 0) we_cyc = cyc; end
         if (done) begin n_done++; done_cyc = cyc; end
         if (err) begin n_err++; err_cyc = cyc; end
         if (aborted) n_abort++;
         check("strobe_start_we", 32'(start & we_rl), 0);
         check("strobe_we_pop", 32'(we_rl & fifo_read_enable), 0);
         check("start_without_pop", 32'(start & ~fifo_read_enable), 0);
         if (valid_address) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_address", 32'(sram_address), 32'hFFFF);
            else check("sram_address", 32'(sram_address), 32'(exp_q.pop_front()));
         end else begin
            check("idle_address_zero", 32'(sram_address), 0);
         end
      end
   end

   task automatic clear_counts();
      cyc = 0; n_start = 0; n_we = 0; n_valid = 0; n_done = 0; n_err = 0; n_abort = 0;
      done_cyc = -1; start_cyc = -1; we_cyc = -1; err_cyc = -1;
      pop_cycs.delete();
   endtask

   task automatic send_cmd(input int base, input int len, input int tiles);
      int waited = 0;
      @(negedge clk);
      while (!cmd_bus.cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("cmd_ready_before_cmd", 32'(cmd_bus.cmd_ready), 1);
      if (tiles >= 1 && tiles <= DEPTH)
         for (int t = 0; t < tiles; t++)
            for (int k = 0; k < len; k++)
               exp_q.push_back(AW'((base + k) % (1 << AW)));
      #1;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_base  = AW'(base);
      cmd_bus.cmd_len   = 11'(len);
      cmd_bus.cmd_tiles = 3'(tiles);
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b0;
      clear_counts();
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check("reach_cycle", 32'(cyc >= target), 1);
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (n_done == 0 && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      check("done_seen", 32'(n_done != 0), 1);
      @(negedge clk); #1;
      check("done_single_pulse", n_done, 1);
   endtask

   initial begin
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_base  = '0;
      cmd_bus.cmd_len   = '0;
      cmd_bus.cmd_tiles = '0;
      clear_counts();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(cmd_bus.cmd_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_aborted", 32'(aborted), 0);
      check("rst_valid", 32'(valid_address), 0);
      check("rst_sram", 32'(sram_address), 0);
      check("rst_we_rl", 32'(we_rl), 0);
      check("rst_pop", 32'(fifo_read_enable), 0);
      rstn = 1'b1;
      mon_en = 1'b1;

      // basic run
      send_cmd(0, 8, 1);
      wait_done(100);
      check("basic_done_cyc", done_cyc, 27);
      check("basic_pops", pop_cycs.size(), 1);
      check("basic_pop_cyc", pop_cycs[0], 1);
      check("basic_start_cyc", start_cyc, 1);
      check("basic_we_cyc", we_cyc, 2);
      check("basic_valid_cnt", n_valid, 8);
      check("basic_err", n_err, 0);
      check("basic_queue_left", exp_q.size(), 0);

      // four tiles, FIFO empty for 5 cycles before the second tile
      send_cmd(0, 3, 4);
      wait_cyc(1);
      @(posedge clk); #1;
      fifo_empty = 1'b1;
      wait_cyc(26);
      @(posedge clk); #1;
      fifo_empty = 1'b0;
      wait_done(200);
      check("multi_done_cyc", done_cyc, 4 * 21 + 1 + 5);
      check("multi_pops", pop_cycs.size(), 4);
      check("multi_pop2_cyc", pop_cycs[1], 27);
      check("multi_starts", n_start, 1);
      check("multi_we", n_we, 4);
      check("multi_valid_cnt", n_valid, 12);
      check("multi_queue_left", exp_q.size(), 0);

      // address wrap
      send_cmd(1022, 4, 1);
      wait_done(100);
      check("wrap_done_cyc", done_cyc, 23);
      check("wrap_valid_cnt", n_valid, 4);
      check("wrap_queue_left", exp_q.size(), 0);

      // zero tiles
      send_cmd(7, 5, 0);
      wait_done(20);
      check("t0_done_cyc", done_cyc, 1);
      check("t0_pops", pop_cycs.size(), 0);
      check("t0_we", n_we, 0);
      check("t0_valid", n_valid, 0);
      check("t0_err", n_err, 0);

      // too many tiles
      send_cmd(7, 5, 5);
      wait_done(20);
      check("t5_done_cyc", done_cyc, 1);
      check("t5_err_cnt", n_err, 1);
      check("t5_err_cyc", err_cyc, 1);
      check("t5_pops", pop_cycs.size(), 0);

      // zero length
      send_cmd(9, 0, 1);
      wait_done(100);
      check("len0_done_cyc", done_cyc, 19);
      check("len0_pops", pop_cycs.size(), 1);
      check("len0_we", n_we, 1);
      check("len0_valid", n_valid, 0);

      // abort at k=2
      send_cmd(100, 8, 2);
      wait_cyc(4);
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk); #1;
      check("abort_cyc_valid", 32'(valid_address), 1);
      check("abort_cyc_addr", 32'(sram_address), 102);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk); #1;
      check("abort_aborted", 32'(aborted), 1);
      check("abort_done", 32'(done), 0);
      check("abort_valid", 32'(valid_address), 0);
      check("abort_cmd_ready", 32'(cmd_bus.cmd_ready), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_queue_left", exp_q.size(), 13);
      exp_q.delete();
      repeat (5) @(negedge clk);
      #1;
      check("abort_pulse_cnt", n_abort, 1);
      check("abort_no_done", n_done, 0);

      // reset during DRAIN
      send_cmd(0, 2, 1);
      wait_cyc(7);
      @(posedge clk); #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk); #1;
      check("rstmid_cmd_ready", 32'(cmd_bus.cmd_ready), 1);
      check("rstmid_busy", 32'(busy), 0);
      check("rstmid_valid", 32'(valid_address), 0);
      check("rstmid_sram", 32'(sram_address), 0);
      check("rstmid_we", 32'(we_rl), 0);
      check("rstmid_pop", 32'(fifo_read_enable), 0);
      repeat (20) @(negedge clk);
      #1;
      check("rstmid_no_done", n_done, 0);
      check("rstmid_no_abort", n_abort, 0);
      check("rstmid_queue_left", exp_q.size(), 0);

      send_cmd(5, 3, 2);
      wait_done(200);
      check("post_rst_done_cyc", done_cyc, 43);
      check("post_rst_pops", pop_cycs.size(), 2);
      check("post_rst_starts", n_start, 1);
      check("post_rst_valid", n_valid, 6);
      check("post_rst_queue_left", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule

// File: doc/tpu_run_ctrl.md
# tpu_run_ctrl

Hardware run sequencer for the systolic-array TPU top level. It replaces hand-timed host stimulus with a command-driven FSM. For each accepted command it:
- pops up to FIFO_DEPTH weight tiles from the weight FIFO, one at a time;
- latches each tile into the PE array;
- streams a contiguous block of activation SRAM addresses through the array;
- waits out the pipeline drain, then moves to the next tile.

It sits between the host command port and the TOP_tpu control pins: start, fifo_read_enable, we_rl, valid_address and sram_address.

## Interface
Parameters:
- ADDRESSSIZE, 10, activation SRAM address width
- NUM_PE_ROWS, 8, PE rows in the array
- MATRIX_SIZE, 8, PE columns / matrix dimension
- FIFO_DEPTH, 4, weight FIFO depth (maximum tiles per command)
- DRAIN_CYCLES, MATRIX_SIZE+NUM_PE_ROWS, wait after the last activation of a tile

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high iff FSM is in IDLE
- cmd_base  in  ADDRESSSIZE  first activation address
- cmd_len  in  ADDRESSSIZE+1  activation rows per tile, 0..2^ADDRESSSIZE
- cmd_tiles  in  $clog2(FIFO_DEPTH+1)  weight tiles to run
- abort  in  1  synchronous abort
- fifo_empty  in  1  weight FIFO empty
- fifo_read_enable  out  1  weight FIFO pop
- start  out  1  array start strobe
- we_rl  out  1  load popped weights into PEs
- valid_address  out  1  sram_address is a live activation read
- sram_address  out  ADDRESSSIZE  activation read address
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: illegal command
- aborted  out  1  one-cycle pulse: run abandoned

## Operation
- **States:** IDLE, POP, LOAD, STREAM, DRAIN, DONE.
- **IDLE:**
  - Command handshake is cmd_valid & cmd_ready.
  - On the handshake, latch base, len and tiles, and clear the tile counter t and row counter k.
  - Next state:
    - cmd_tiles == 0 → DONE.
    - cmd_tiles > FIFO_DEPTH → DONE with err.
    - otherwise → POP.
- **POP:**
  - fifo_read_enable = !fifo_empty.
  - start = 1 only when t == 0 and !fifo_empty.
  - While fifo_empty is high, stall in POP with no pop.
  - Go to LOAD on the cycle the pop occurs.
- **LOAD:** we_rl = 1 for exactly one cycle. Next state is STREAM if len ≠ 0, else DRAIN.
- **STREAM:**
  - valid_address = 1 and sram_address = (base + k) mod 2^ADDRESSSIZE.
  - k counts 0..len-1.
  - Go to DRAIN after k == len-1.
  - The address wraps silently past 2^ADDRESSSIZE-1.
- **DRAIN:**
  - Count DRAIN_CYCLES cycles with all strobes low.
  - Then t += 1 and k = 0.
  - Next state is POP if t < tiles, else DONE.
- **DONE:** pulse done (and err, if flagged) for one cycle, then IDLE. done is also pulsed on the error path.
- **abort:**
  - When abort is high in any state other than IDLE, the next state is IDLE.
  - All strobes go low on the next cycle; aborted pulses and done does not.
  - abort in IDLE is ignored.
  - abort takes priority over every other transition, including a pop in the same cycle: fifo_read_enable is still asserted that cycle, and the tile is consumed.
- **Strobe rule:** start, we_rl and fifo_read_enable are never high in the same cycle except that start and fifo_read_enable coincide in the first POP.

## Timing
- **Reset values** (all registers cleared, state = IDLE):
  - cmd_ready = 1;
  - every other output = 0;
  - sram_address = 0.
- **Registered outputs:** all outputs except fifo_read_enable and start are decoded from registers only.
  - fifo_read_enable and start are gated combinationally by fifo_empty.
- **Latency with no stalls:** from the handshake edge to the done pulse is tiles·(2 + len + DRAIN_CYCLES) + 1 cycles.
  - POP is entered in the cycle after the handshake.
- **Idle sram_address:** holds 0 whenever valid_address = 0.
- **Reset mid-run:** rstn low on any edge returns to the reset state on that edge. No done or aborted pulse is produced.
- **Back-to-back commands:** a new command is accepted in the first IDLE cycle after DONE.

## Structure
- **Shared package tpu_pkg:**
  - state enum tpu_run_state_t;
  - DRAIN_CYCLES default;
  - width helper for the tile counter.
- **One sub-module, tpu_addr_gen:**
  - inputs: base, len, step enable;
  - outputs: address, last flag;
  - modulo-2^ADDRESSSIZE adder.
- **Top:** tpu_run_ctrl holds the FSM, tile counter and drain counter.

## Test plan
- **Basic run:**
  - Stimulus: base=0, len=8, tiles=1, FIFO non-empty.
  - Response: start+pop in 1 cycle, we_rl the next cycle, then addresses 0..7 with valid_address, then 16 drain cycles; done at cycle 27 after the handshake.
- **Multiple tiles with empty stall:**
  - Stimulus: tiles=4, len=3; fifo_empty held high for 5 cycles before tile 2.
  - Response: exactly 4 pops; start only once; tile-2 POP stretched by 5 cycles; total 4·21 + 1 + 5 cycles.
- **Address wrap:**
  - Stimulus: base=1022, len=4.
  - Response: sram_address sequence 1022, 1023, 0, 1.
- **Degenerate commands:**
  - tiles=0 → done 1 cycle after the handshake, no strobes.
  - tiles=5 (FIFO_DEPTH=4) → done+err pulse, no pop.
  - len=0 → pop, we_rl, drain, done, with valid_address never high.
- **Abort mid-STREAM:**
  - Stimulus: abort high at k=2.
  - Response: next cycle is IDLE, valid_address=0, aborted=1, done=0; cmd_ready=1.
- **Reset mid-DRAIN:**
  - Stimulus: rstn low for 1 edge during DRAIN.
  - Response: all outputs at reset values, no pulses; a new command runs normally afterwards.
